// File: rtl/am2901_useq_if.sv
// Sequencer <-> microcode ROM / Am2901 / host bundle; the master side is the sequencer.
// Combinational uaddr out, registered Am2901 control pins; no backpressure on any signal.
interface am2901_useq_if #(
   parameter int UADDR_W = 6
);
   logic               start;
   logic [UADDR_W-1:0] start_addr;
   logic [UADDR_W-1:0] uaddr;
   logic [32:0]        uword;
   logic               z;
   logic               ovr;
   logic               cout;
   logic               f3;
   logic [8:0]         i_out;
   logic [3:0]         a_out;
   logic [3:0]         b_out;
   logic [3:0]         d_out;
   logic               cin_out;
   logic               oe_out;
   logic               busy;
   logic               done;
   logic               err;

   modport master (
      input  start, start_addr, uword, z, ovr, cout, f3,
      output uaddr, i_out, a_out, b_out, d_out, cin_out, oe_out, busy, done, err
   );

   modport slave (
      output start, start_addr, uword, z, ovr, cout, f3,
      input  uaddr, i_out, a_out, b_out, d_out, cin_out, oe_out, busy, done, err
   );
endinterface

// File: rtl/am2901_useq.sv
// Am2901 microprogram sequencer: one-stage pipeline register, combinational next-address to ROM.
// One microword per cycle while running; flags reach uaddr in the same cycle; no backpressure.
module am2901_useq #(
   parameter int UADDR_W     = 6,
   parameter int STACK_DEPTH = 4
) (
   input  logic          cp,
   input  logic          rst_lo,
   am2901_useq_if.master bus
);
   localparam int DW = $clog2(STACK_DEPTH + 1);
   localparam int SW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

   localparam logic [32:0] NOP = {9'h05C, 24'h0};

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] RUN  = 1'b1;

   localparam logic [2:0] OP_CONT = 3'd0;
   localparam logic [2:0] OP_JMP  = 3'd1;
   localparam logic [2:0] OP_CJMP = 3'd2;
   localparam logic [2:0] OP_CALL = 3'd3;
   localparam logic [2:0] OP_RET  = 3'd4;
   localparam logic [2:0] OP_LDCT = 3'd5;
   localparam logic [2:0] OP_LOOP = 3'd6;
   localparam logic [2:0] OP_HALT = 3'd7;

   logic [0:0]         state;
   logic [32:0]        pipe;
   logic [UADDR_W-1:0] upc;
   logic [UADDR_W-1:0] cnt;
   logic [DW-1:0]      depth;
   logic               done;
   logic               err;
   logic [UADDR_W-1:0] stack [STACK_DEPTH];

   logic [2:0]         seq_op;
   logic [1:0]         cond;
   logic [UADDR_W-1:0] target;
   logic               flag;
   logic               stack_full;
   logic               stack_empty;
   logic [SW-1:0]      wr_idx;
   logic [SW-1:0]      rd_idx;

   logic [UADDR_W-1:0] uaddr_n;
   logic               halt;
   logic               fault;
   logic               push;
   logic               pop;
   logic               cnt_ld;
   logic               cnt_dec;

   assign seq_op      = pipe[10:8];
   assign cond        = pipe[7:6];
   assign target      = UADDR_W'(pipe[5:0]);
   assign stack_full  = (depth == DW'(STACK_DEPTH));
   assign stack_empty = (depth == '0);
   assign wr_idx      = SW'(depth);
   assign rd_idx      = SW'(depth - DW'(1));

   always_comb begin
      flag = bus.z;
      case (cond)
         2'b00:   flag = bus.z;
         2'b01:   flag = bus.ovr;
         2'b10:   flag = bus.cout;
         default: flag = bus.f3;
      endcase
   end

   // Next-address decode; a stack fault turns CALL/RET into HALT without touching the stack.
   always_comb begin
      uaddr_n = upc;
      halt    = 1'b0;
      fault   = 1'b0;
      push    = 1'b0;
      pop     = 1'b0;
      cnt_ld  = 1'b0;
      cnt_dec = 1'b0;
      if (state == IDLE) begin
         uaddr_n = bus.start_addr;
      end else begin
         case (seq_op)
            OP_CONT: uaddr_n = upc;
            OP_JMP:  uaddr_n = target;
            OP_CJMP: if (flag) uaddr_n = target;
            OP_CALL: begin
               if (stack_full) begin
                  halt  = 1'b1;
                  fault = 1'b1;
               end else begin
                  uaddr_n = target;
                  push    = 1'b1;
               end
            end
            OP_RET: begin
               if (stack_empty) begin
                  halt  = 1'b1;
                  fault = 1'b1;
               end else begin
                  uaddr_n = stack[rd_idx];
                  pop     = 1'b1;
               end
            end
            OP_LDCT: cnt_ld = 1'b1;
            OP_LOOP: begin
               if (cnt != '0) begin
                  uaddr_n = target;
                  cnt_dec = 1'b1;
               end
            end
            default: halt = 1'b1;
         endcase
      end
   end

   always_ff @(posedge cp or negedge rst_lo) begin
      if (!rst_lo) begin
         state <= IDLE;
         pipe  <= NOP;
         upc   <= '0;
         cnt   <= '0;
         depth <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
      end else begin
         done <= 1'b0;
         if (state == IDLE) begin
            if (bus.start) begin
               state <= RUN;
               pipe  <= bus.uword;
               upc   <= uaddr_n + UADDR_W'(1);
               depth <= '0;
               cnt   <= '0;
               err   <= 1'b0;
            end
         end else if (halt) begin
            state <= IDLE;
            pipe  <= NOP;
            done  <= 1'b1;
            if (fault) err <= 1'b1;
         end else begin
            pipe <= bus.uword;
            upc  <= uaddr_n + UADDR_W'(1);
            if (push) depth <= depth + DW'(1);
            else if (pop) depth <= depth - DW'(1);
            if (cnt_ld) cnt <= target;
            else if (cnt_dec) cnt <= cnt - UADDR_W'(1);
         end
      end
   end

   // Stack contents need no reset: depth alone says which entries are valid.
   always_ff @(posedge cp) begin
      if (push) stack[wr_idx] <= upc;
   end

   assign bus.uaddr   = uaddr_n;
   assign bus.i_out   = pipe[32:24];
   assign bus.a_out   = pipe[23:20];
   assign bus.b_out   = pipe[19:16];
   assign bus.d_out   = pipe[15:12];
   assign bus.cin_out = pipe[11];
   assign bus.oe_out  = (state == RUN);
   assign bus.busy    = (state == RUN);
   assign bus.done    = done;
   assign bus.err     = err;
endmodule
